lfsr_word_packer: RTL and testbench

Downstream consumer of the `lfsr` serial stream. It paces the generator through its `advance`/`reinit` controls, packs successive `out` bits LSB-first into `WORD_W`-bit words, and presents each word on a one-deep valid/ready output register. It also sequences reseed requests into a clean `reinit` pulse and discards any partial word when it does so.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_word_packer.sv | 101 ++++++++++
 tb/tb_lfsr_word_packer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR word packer.
// FSM encoding and default word width.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESEED
    } lfsr_pkt_state_e;

    localparam int WORD_W_DEFAULT = 8;

endpackage

// File: rtl/lfsr_word_packer.sv
// Paces an LFSR, packs its serial bits LSB-first into words,
// and offers each word on a one-deep valid/ready register.
module lfsr_word_packer
    import lfsr_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              reseed_req,
    input  logic              lfsr_out,
    output logic              lfsr_advance,
    output logic              lfsr_reinit,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  word_count
);

    localparam int BW = $clog2(WORD_W);

    lfsr_pkt_state_e st, nxt;

    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] sreg;
    logic [WORD_W-1:0] full;
    logic              last;
    logic              stall;
    logic              capture;
    logic              xfer;

    assign full  = {lfsr_out, sreg};
    assign last  = (bit_cnt == BW'(WORD_W - 1));
    assign stall = last && word_valid && !word_ready;
    assign xfer  = word_valid && word_ready;

    // IDLE with enable already captures so the first bit
    // lands in the same cycle enable is first seen.
    assign capture = rst_n && enable && !reseed_req && !stall
                     && (st == IDLE || st == FILL);

    assign lfsr_advance = capture;
    assign lfsr_reinit  = rst_n && (st == RESEED);

    always_comb begin
        nxt = st;
        case (st)
            IDLE: begin
                if (reseed_req)
                    nxt = RESEED;
                else if (enable)
                    nxt = FILL;
            end
            FILL: begin
                if (reseed_req)
                    nxt = RESEED;
                else if (!enable)
                    nxt = IDLE;
            end
            RESEED: nxt = enable ? FILL : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_count <= '0;
        end else begin
            st <= nxt;

            if (st == RESEED) begin
                bit_cnt <= '0;
                sreg    <= '0;
            end else if (capture) begin
                sreg <= full[WORD_W-1:1];
                if (last) begin
                    bit_cnt   <= '0;
                    word_data <= full;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end

            if (capture && last)
                word_valid <= 1'b1;
            else if (xfer)
                word_valid <= 1'b0;

            if (xfer)
                word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Directed bench for lfsr_word_packer with an inline
// Galois LFSR model feeding its serial input.
module tb_lfsr_word_packer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       reseed_req;
    logic       word_ready;
    logic [4:0] taps;
    logic [4:0] seed;
    logic [4:0] lstate;
    logic       lfsr_out;

    logic       adv, reinit, valid;
    logic [7:0] data;
    logic [15:0] count;

    logic       adv2, reinit2, valid2;
    logic [7:0] data2;
    logic [1:0] count2;

    int n_cmp;
    int n_err;

    lfsr_word_packer #(.WORD_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .reseed_req   (reseed_req),
        .lfsr_out     (lfsr_out),
        .lfsr_advance (adv),
        .lfsr_reinit  (reinit),
        .word_data    (data),
        .word_valid   (valid),
        .word_ready   (word_ready),
        .word_count   (count)
    );

    lfsr_word_packer #(.WORD_W(8), .CNT_W(2)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .reseed_req   (reseed_req),
        .lfsr_out     (lfsr_out),
        .lfsr_advance (adv2),
        .lfsr_reinit  (reinit2),
        .word_data    (data2),
        .word_valid   (valid2),
        .word_ready   (word_ready),
        .word_count   (count2)
    );

    // Reference LFSR: out is state[0]; advance shifts right and
    // folds taps in when the outgoing bit is 1.
    assign lfsr_out = lstate[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lstate <= seed;
        else if (reinit)
            lstate <= seed;
        else if (adv)
            lstate <= (lstate >> 1) ^ (lstate[0] ? taps : 5'b0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [4:0] t);
        @(negedge clk);
        rst_n      = 1'b0;
        enable     = 1'b0;
        word_ready = 1'b0;
        reseed_req = 1'b0;
        taps       = t;
        seed       = 5'b00001;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap_adv;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        reseed_req = 1'b0;
        word_ready = 1'b0;
        taps       = 5'b0;
        seed       = 5'b00001;

        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_adv", 32'(adv), 32'h0);
        chk("rst_reinit", 32'(reinit), 32'h0);

        // Zero taps: 1 then all zeros.
        do_reset(5'b00000);
        enable     = 1'b1;
        word_ready = 1'b1;
        #1;
        chk("zt_adv0", 32'(adv), 32'h1);
        repeat (7) @(negedge clk);
        chk("zt_valid_early", 32'(valid), 32'h0);
        @(negedge clk);
        chk("zt_valid1", 32'(valid), 32'h1);
        chk("zt_word1", 32'(data), 32'h01);
        repeat (8) @(negedge clk);
        chk("zt_word2", 32'(data), 32'h00);
        chk("zt_valid2", 32'(valid), 32'h1);
        chk("zt_count1", 32'(count), 32'h1);
        repeat (8) @(negedge clk);
        chk("zt_count2", 32'(count), 32'h2);

        // Alternating stream and counter wrap on the narrow counter.
        do_reset(5'b00010);
        enable     = 1'b1;
        word_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("alt_word1", 32'(data), 32'h55);
        chk("alt_valid1", 32'(valid), 32'h1);
        repeat (16) @(negedge clk);
        chk("alt_word3", 32'(data), 32'h55);
        chk("alt_count2", 32'(count), 32'h2);
        repeat (24) @(negedge clk);
        chk("wrap_count16", 32'(count), 32'h5);
        chk("wrap_count2", 32'(count2), 32'h1);
        chk("wrap_data2", 32'(data2), 32'h55);
        chk("wrap_valid2", 32'(valid2), 32'h1);
        chk("wrap_adv2", 32'(adv2), 32'h1);
        chk("wrap_reinit2", 32'(reinit2), 32'h0);

        // Backpressure: stall at bit_cnt 7, then release.
        do_reset(5'b00010);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_word1", 32'(data), 32'h55);
        chk("bp_valid1", 32'(valid), 32'h1);
        repeat (6) @(negedge clk);
        chk("bp_adv_b6", 32'(adv), 32'h1);
        @(negedge clk);
        chk("bp_adv_stall", 32'(adv), 32'h0);
        repeat (5) @(negedge clk);
        chk("bp_adv_held", 32'(adv), 32'h0);
        chk("bp_data_held", 32'(data), 32'h55);
        chk("bp_count_held", 32'(count), 32'h0);
        word_ready = 1'b1;
        #1;
        chk("bp_adv_resume", 32'(adv), 32'h1);
        @(negedge clk);
        chk("bp_word2", 32'(data), 32'h55);
        chk("bp_valid2", 32'(valid), 32'h1);
        chk("bp_count1", 32'(count), 32'h1);

        // Mid-word reseed after 3 captured bits.
        do_reset(5'b00010);
        enable     = 1'b1;
        word_ready = 1'b1;
        repeat (3) @(negedge clk);
        reseed_req = 1'b1;
        #1;
        chk("rs_adv_req", 32'(adv), 32'h0);
        @(negedge clk);
        reseed_req = 1'b0;
        chk("rs_reinit", 32'(reinit), 32'h1);
        chk("rs_adv", 32'(adv), 32'h0);
        @(negedge clk);
        chk("rs_reinit_off", 32'(reinit), 32'h0);
        chk("rs_adv_on", 32'(adv), 32'h1);
        repeat (5) @(negedge clk);
        chk("rs_no_early", 32'(valid), 32'h0);
        repeat (3) @(negedge clk);
        chk("rs_word", 32'(data), 32'h55);
        chk("rs_valid", 32'(valid), 32'h1);

        // Enable gap mid-word, then reset during a stall.
        do_reset(5'b00010);
        enable     = 1'b1;
        word_ready = 1'b1;
        repeat (3) @(negedge clk);
        enable  = 1'b0;
        gap_adv = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            gap_adv += int'(adv);
            @(negedge clk);
        end
        chk("gap_adv", 32'(gap_adv), 32'h0);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("gap_no_early", 32'(valid), 32'h0);
        @(negedge clk);
        chk("gap_word", 32'(data), 32'h55);
        chk("gap_valid", 32'(valid), 32'h1);
        word_ready = 1'b0;
        repeat (7) @(negedge clk);
        chk("gap_stall_adv", 32'(adv), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("ar_data", 32'(data), 32'h0);
        chk("ar_valid", 32'(valid), 32'h0);
        chk("ar_count", 32'(count), 32'h0);
        chk("ar_adv", 32'(adv), 32'h0);
        chk("ar_reinit", 32'(reinit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
